// File: rtl/clock_time_ctrl_if.sv
// Bundle between the clock sequencer and the six-digit BCD counter datapath.
// master: button/tick source plus counter Q readback; slave: the sequencer.
interface clock_time_ctrl_if;
  logic        tick;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic [23:0] q;      // {h1,h0,m1,m0,s1,s0}
  logic [5:0]  en;     // bit0=s0 .. bit5=h1
  logic [5:0]  dir;    // 1=up
  logic [5:0]  load;
  logic [23:0] d;      // same packing as q
  logic [1:0]  mode;
  logic        blink;

  modport master (
    output tick, btn_mode, btn_up, btn_down, q,
    input  en, dir, load, d, mode, blink
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, q,
    output en, dir, load, d, mode, blink
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Sequencing controller for a six-digit BCD clock built from mod-10 up/down
// counters. Owns the mode FSM, latches one command per cycle, and decodes that
// command against the live digits into per-digit En/dir/Load/D strobes. Tens
// digits (mod 6) and the 24-hour wrap are produced with loads.
// Optional: define CLOCK_SET_SEC_EN to add a SET_SEC mode (up/down clears seconds).
module clock_time_ctrl #(
  parameter bit TICK_IN_SET = 1'b0  // 1: seconds keep running in set modes
) (
  input logic              CP,
  input logic              nCLR,
  clock_time_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ModeRun    = 2'd0,
    ModeSetHr  = 2'd1,
    ModeSetMin = 2'd2,
    ModeSetSec = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    CmdNone, CmdIncS, CmdIncH, CmdDecH, CmdIncM, CmdDecM, CmdClrS
  } cmd_e;

  mode_e mode_q, mode_d;
  cmd_e  cmd_q, cmd_d;
  logic  blink_q, blink_d;

  logic  step;     // exactly one of up/down
  logic  btn_any;

  logic [3:0] s0, s1, m0, m1, h0, h1;
  logic       inc_min, inc_hr;
  logic [5:0] en, dir, load;
  logic [23:0] d;

  assign {h1, h0, m1, m0, s1, s0} = bus.q;

  // Mode transitions, command selection and blink next state.
  always_comb begin
    mode_d  = mode_q;
    cmd_d   = CmdNone;
    blink_d = blink_q;
    step    = bus.btn_up ^ bus.btn_down;
    btn_any = bus.btn_mode | bus.btn_up | bus.btn_down;
    case (mode_q)
      ModeRun: begin
        blink_d = 1'b0;
        // A tick coinciding with btn_mode still counts in RUN.
        if (bus.tick) cmd_d = CmdIncS;
        if (bus.btn_mode) mode_d = ModeSetHr;
      end
      ModeSetHr: begin
        if (bus.btn_mode) mode_d = ModeSetMin;
        else if (step) cmd_d = bus.btn_up ? CmdIncH : CmdDecH;
      end
      ModeSetMin: begin
        if (bus.btn_mode) begin
`ifdef CLOCK_SET_SEC_EN
          mode_d = ModeSetSec;
`else
          mode_d = ModeRun;
          cmd_d  = CmdClrS;
`endif
        end else if (step) begin
          cmd_d = bus.btn_up ? CmdIncM : CmdDecM;
        end
      end
`ifdef CLOCK_SET_SEC_EN
      ModeSetSec: begin
        if (bus.btn_mode) mode_d = ModeRun;
        else if (step) cmd_d = CmdClrS;
      end
`endif
      default: mode_d = ModeRun;
    endcase
    if (mode_q != ModeRun) begin
      if (bus.tick) blink_d = ~blink_q;
      // Any button in a set mode swallows a coincident tick.
      if (TICK_IN_SET && bus.tick && !btn_any) cmd_d = CmdIncS;
    end
    if (mode_d != mode_q) blink_d = 1'b0;
  end

  // Command, mode and blink registers; reset drops any pending command.
  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      mode_q  <= ModeRun;
      cmd_q   <= CmdNone;
      blink_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      blink_q <= blink_d;
    end
  end

  // Decode the latched command against the live digits into counter strobes.
  always_comb begin
    en      = '0;
    dir     = '1;
    load    = '0;
    d       = '0;
    inc_min = 1'b0;
    inc_hr  = 1'b0;
    case (cmd_q)
      CmdIncS: begin
        en[0] = 1'b1;
        if (s0 == 4'd9) begin
          if (s1 == 4'd5) load[1] = 1'b1;
          else            en[1]   = 1'b1;
        end
        if (s1 == 4'd5 && s0 == 4'd9) begin
          inc_min = 1'b1;
          if (m1 == 4'd5 && m0 == 4'd9) inc_hr = 1'b1;
        end
      end
      CmdIncM: inc_min = 1'b1;
      CmdIncH: inc_hr  = 1'b1;
      CmdDecH: begin
        if (h1 == 4'd0 && h0 == 4'd0) begin
          load[5:4] = 2'b11;
          d[23:20]  = 4'd2;
          d[19:16]  = 4'd3;
        end else begin
          en[4]  = 1'b1;
          dir[4] = 1'b0;
          if (h0 == 4'd0) begin
            en[5]  = 1'b1;
            dir[5] = 1'b0;
          end
        end
      end
      CmdDecM: begin
        en[2]  = 1'b1;
        dir[2] = 1'b0;
        if (m0 == 4'd0) begin
          if (m1 == 4'd0) begin
            load[3]  = 1'b1;
            d[15:12] = 4'd5;
          end else begin
            en[3]  = 1'b1;
            dir[3] = 1'b0;
          end
        end
      end
      CmdClrS: load[1:0] = 2'b11;
      default: ;
    endcase
    if (inc_min) begin
      en[2] = 1'b1;
      if (m0 == 4'd9) begin
        if (m1 == 4'd5) load[3] = 1'b1;
        else            en[3]   = 1'b1;
      end
    end
    if (inc_hr) begin
      if (h1 == 4'd2 && h0 == 4'd3) begin
        load[5:4] = 2'b11;
      end else begin
        en[4] = 1'b1;
        if (h0 == 4'd9) en[5] = 1'b1;
      end
    end
  end

  assign bus.en    = en;
  assign bus.dir   = dir;
  assign bus.load  = load;
  assign bus.d     = d;
  assign bus.mode  = mode_q;
  assign bus.blink = blink_q;

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Sequencing controller for the six-digit BCD time datapath (ss, mm, hh; six identical mod-10 up/down counters with load).
- Owns the mode FSM (run / set hours / set minutes).
- Converts a 1 Hz tick and debounced button pulses into per-digit En/dir/Load/D strobes.
- Enforces mod-6 tens digits and the 24-hour wrap by issuing loads, because every digit counter natively wraps only 9<->0.

Parameters:
- TICK_IN_SET, 0, 1 = seconds keep counting while in a set mode; 0 = time frozen in set modes.

Ports:
- CP  input  1  system clock; all state changes on rising edge
- nCLR  input  1  asynchronous active-low reset
- tick  input  1  one-CP-wide 1 Hz enable pulse
- btn_mode  input  1  one-CP-wide pulse, advance mode
- btn_up  input  1  one-CP-wide pulse, increment selected field
- btn_down  input  1  one-CP-wide pulse, decrement selected field
- q  input  24  current digits {h1,h0,m1,m0,s1,s0}, 4 bits each, from counter Q outputs
- en  output  6  per-digit counter En, bit0=s0 .. bit5=h1
- dir  output  6  per-digit counter dir (1=up, 0=down)
- load  output  6  per-digit counter Load
- d  output  24  per-digit load value, same packing as q
- mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC (only with option)
- blink  output  1  display blank strobe for the selected field

Behaviour:
- Reset (nCLR low, async): mode=RUN, pending command=NONE, blink=0.
  - en, load and d read 0; dir reads all 1 (idle up).
  - A pending command is discarded if reset asserts mid-sequence.
- Registered command stage: each cycle one of NONE, INC_S, INC_H, DEC_H, INC_M, DEC_M, CLR_S is latched from the inputs.
  - en/dir/load/d are combinational from that command and the live q.
  - Latency: event in cycle n -> strobes in cycle n+1 -> digits updated at end of n+1.
  - Exactly one command per cycle; strobes are 0 whenever the command is NONE.
- Command selection, by mode:
  - RUN: tick -> INC_S; up/down ignored.
  - SET_HR: up -> INC_H; down -> DEC_H.
  - SET_MIN: up -> INC_M; down -> DEC_M.
  - Ticks in set modes -> INC_S only if TICK_IN_SET=1.
- Priority and simultaneous events:
  - btn_mode beats up/down: the button action is dropped and the mode advances.
  - up and down in the same cycle: both dropped.
  - tick and button in the same cycle: button wins; the tick is lost in set modes.
  - In RUN, tick and btn_mode together: INC_S is issued and the mode also advances.
- Mode FSM on btn_mode: RUN -> SET_HR -> SET_MIN -> RUN.
  - On the SET_MIN -> RUN transition, CLR_S is issued: load s1=s0=0.
- INC_S carry chain (all dir=1):
  - s0 en.
  - If s0==9: s1 en; if s1==5, s1 load 0 instead.
  - If s1:s0==59: m0 en.
  - If additionally m0==9: m1 en (m1==5 -> load 0).
  - If mm:ss==59:59: hour increment as INC_H.
- INC_H:
  - hh==23 -> load h1=0, h0=0.
  - Else h0 en up; if h0==9, h1 en up.
- DEC_H:
  - hh==00 -> load h1=2, h0=3.
  - Else h0 en down; if h0==0, h1 en down.
- INC_M: as the minute portion of INC_S, but 59 -> 00 produces no hour carry.
- DEC_M:
  - m0 en down.
  - If m0==0: m1 en down, or load m1=5 if m1==0.
  - No hour borrow.
- A digit receiving load has its en/dir don't-care; load takes precedence in the counter.
- Out-of-range digit values on q (e.g. hh=24, digit>9): no correction; the resulting strobes are unspecified.
- blink: 0 in RUN; toggles on every tick in set modes; forced to 0 on every mode change.

Optional Feature:
- CLOCK_SET_SEC_EN
  - Defined: mode sequence becomes RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN. In SET_SEC, up or down -> CLR_S; leaving SET_SEC issues no CLR_S.
  - Undefined: three-mode sequence as above; mode never reads 3.

Test Plan:
- Reset with q=12:34:56, nCLR pulsed low -> mode=0, en=load=0, blink=0 immediately, before any CP edge.
- RUN, q=23:59:59, tick -> next cycle: en[0]=1, en[2]=1, load[1]=load[3]=load[4]=load[5]=1, d=0 on loaded digits; digits update to 00:00:00 (s0 via its own 9->0 wrap).
- SET_HR, q hh=00, btn_down -> load[5:4]=2'b11, d h1=2, h0=3. Then with hh=19, btn_up -> en[4]=en[5]=1, dir=1, no load.
- SET_MIN, q mm=00, btn_down -> en[2]=1 dir[2]=0, load[3]=1 d m1=5; hour strobes all 0.
- SET_MIN, btn_up and btn_down same cycle -> no strobes. btn_mode with btn_up -> mode=RUN, CLR_S loads s1=s0=0, no minute strobes.
- RUN, tick and btn_mode same cycle with q=00:00:05 -> INC_S issued (en[0]=1), mode=SET_HR, blink=0; the next tick toggles blink to 1.
